// File: rtl/md_unit_if.sv
// md_unit_if: EX-stage multiply/divide request and HI/LO result bundle.
// The pipeline side is master; the md_unit side is slave.
interface md_unit_if;
  logic        start;
  logic [3:0]  MDop;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] MDout;

  modport master (
    output start, MDop, A, B,
    input  busy, HI, LO, MDout
  );

  modport slave (
    input  start, MDop, A, B,
    output busy, HI, LO, MDout
  );
endinterface

// File: rtl/md_unit.sv
// md_unit: multi-cycle MULT/DIV unit owning the architectural HI/LO pair.
// Result is computed at issue and held pending until the latency expires.
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic       clk,
  input logic       reset,
  md_unit_if.slave  bus
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  state_t      state;
  logic        busy_q;
  logic [3:0]  cnt;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [31:0] pend_hi;
  logic [31:0] pend_lo;
  logic        pend_wr;

  logic        is_mul;
  logic        is_div;
  logic        is_md;
  logic        is_mthi;
  logic        is_mtlo;
  logic        b_zero;

  logic [63:0] as_ext;
  logic [63:0] bs_ext;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] bs_safe;
  logic [31:0] bu_safe;
  logic [31:0] qs_mag;
  logic [31:0] rs_mag;
  logic [31:0] qs;
  logic [31:0] rs;
  logic [31:0] qu;
  logic [31:0] ru;
  logic [63:0] res;

  assign is_mul  = (bus.MDop == OP_MULT) | (bus.MDop == OP_MULTU);
  assign is_div  = (bus.MDop == OP_DIV)  | (bus.MDop == OP_DIVU);
  assign is_md   = is_mul | is_div;
  assign is_mthi = (bus.MDop == OP_MTHI);
  assign is_mtlo = (bus.MDop == OP_MTLO);
  assign b_zero  = (bus.B == 32'd0);

  // Operand arithmetic; signed divide works on magnitudes, then fixes signs.
  always_comb begin
    as_ext  = {{32{bus.A[31]}}, bus.A};
    bs_ext  = {{32{bus.B[31]}}, bus.B};
    prod_s  = as_ext * bs_ext;
    prod_u  = {32'd0, bus.A} * {32'd0, bus.B};
    a_mag   = bus.A[31] ? -bus.A : bus.A;
    b_mag   = bus.B[31] ? -bus.B : bus.B;
    bs_safe = b_zero ? 32'd1 : b_mag;
    bu_safe = b_zero ? 32'd1 : bus.B;
    qs_mag  = a_mag / bs_safe;
    rs_mag  = a_mag % bs_safe;
    qs      = (bus.A[31] ^ bus.B[31]) ? -qs_mag : qs_mag;
    rs      = bus.A[31] ? -rs_mag : rs_mag;
    qu      = bus.A / bu_safe;
    ru      = bus.A % bu_safe;
    res     = 64'd0;
    case (bus.MDop)
      OP_MULT:  res = prod_s;
      OP_MULTU: res = prod_u;
      OP_DIV:   res = {rs, qs};
      OP_DIVU:  res = {ru, qu};
      default:  res = 64'd0;
    endcase
  end

  // Control FSM: issue, latency countdown, commit of pending HI/LO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      busy_q  <= 1'b0;
      cnt     <= 4'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_wr <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            unique case (1'b1)
              is_md: begin
                pend_hi <= res[63:32];
                pend_lo <= res[31:0];
                pend_wr <= !(is_div && b_zero);
                cnt     <= is_div ? DIV_N : MULT_N;
                busy_q  <= 1'b1;
                state   <= RUN;
              end
              is_mthi: hi_q <= bus.A;
              is_mtlo: lo_q <= bus.A;
              default: ;
            endcase
          end
        end
        RUN: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            if (pend_wr) begin
              hi_q <= pend_hi;
              lo_q <= pend_lo;
            end
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Combinational HI/LO read port for MFHI/MFLO.
  always_comb begin
    bus.MDout = 32'd0;
    case (bus.MDop)
      OP_MFHI: bus.MDout = hi_q;
      OP_MFLO: bus.MDout = lo_q;
      default: bus.MDout = 32'd0;
    endcase
  end

  assign bus.busy = busy_q;
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

endmodule

// File: doc/md_unit.md
# md_unit

Multiply/divide unit for the EX stage of the pipelined MIPS core. It is the sequential counterpart of the single-cycle ALU: it accepts an operand pair plus an operation, holds `busy` for a fixed multi-cycle latency, then commits the 64-bit result into the architectural HI/LO registers. The hazard unit stalls the pipeline on `busy | start` when a multiply/divide or HI/LO access follows.

## Interface
- MULT_CYCLES, 5, busy cycles for MULT/MULTU
- DIV_CYCLES, 10, busy cycles for DIV/DIVU
- clk  input  1  single clock; all state changes on the rising edge
- reset  input  1  asynchronous, active-low; clears all state immediately
- start  input  1  operation valid this cycle (EX stage holds an MD instruction)
- MDop  input  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO, others treated as NONE
- A  input  32  rs operand (dividend / multiplicand / MTHI-MTLO source)
- B  input  32  rt operand (divisor / multiplier)
- busy  output  1  operation in progress
- HI  output  32  architectural HI register
- LO  output  32  architectural LO register
- MDout  output  32  combinational read: HI when MDop=MFHI, LO when MDop=MFLO, else 0

## Operation
- States: IDLE, RUN. Internal: cycle counter (4 bits), pending HI/LO result registers.
- IDLE, start=1, MDop ∈ {MULT, MULTU, DIV, DIVU}: compute the result from A/B sampled at this edge, store as pending, load counter with MULT_CYCLES or DIV_CYCLES, go RUN.
- IDLE, start=1, MDop=MTHI: HI <= A. MDop=MTLO: LO <= A. Single edge, busy stays 0.
- MFHI/MFLO/NONE: no state change; MDout is a combinational read.
- RUN: counter decrements each edge; on the edge where counter goes 1→0, HI/LO <= pending, go IDLE.
- start while RUN: ignored entirely (including MTHI/MTLO); the pipeline guarantees a stall, and the bench checks that the unit ignores it.
- Arithmetic:
  - MULT: signed 32×32→64, HI = upper, LO = lower.
  - MULTU: unsigned 32×32→64.
  - DIV: signed; LO = quotient truncated toward zero, HI = remainder with the dividend's sign. 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - DIVU: unsigned quotient/remainder.
  - Divide by zero (B=0): the operation still runs DIV_CYCLES with busy high; HI/LO are left unchanged at commit.

## Timing
- Reset: busy=0, HI=0, LO=0, counter=0, pending=0, state IDLE. MDout=0 unless MDop selects HI/LO, which then read 0.
- start sampled at edge E0 (cycle 0) with busy=0. busy=1 during cycles 1..N (N = MULT_CYCLES or DIV_CYCLES). HI/LO update at the edge ending cycle N. busy=0 and the new HI/LO are visible in cycle N+1.
- A new start is accepted in cycle N+1 (back-to-back, no bubble).
- MTHI/MTLO: written at the sampling edge; visible the next cycle.
- MFHI/MFLO during RUN return the old (pre-commit) HI/LO.
- Reset asserted mid-RUN: the operation is aborted immediately, nothing is committed, and HI/LO read 0.
- A/B changing during RUN has no effect on the result.

## Test plan
- Reset, then MTHI A=0x12345678 and MTLO A=0x9ABCDEF0 on consecutive cycles → HI=0x12345678, LO=0x9ABCDEF0; MFHI/MFLO MDout match; busy never asserts.
- MULT A=0xFFFFFFFF, B=2 → busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE. MULTU with the same operands → HI=1, LO=0xFFFFFFFE.
- DIV A=0xFFFFFFF9 (-7), B=2 → busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=7, B=2 → LO=3, HI=1. DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU with B=0 after HI=5, LO=6 → busy 10 cycles, HI=5, LO=6 unchanged.
- During MULT RUN: pulse start with MTLO A=0xDEAD and with DIV → both ignored. MFLO reads the old LO until commit. A second MULT issued in cycle N+1 is accepted.
- Assert reset in cycle 3 of a DIV → busy=0 and HI=LO=0 immediately. After release, the unit is IDLE and accepts a new MULTU.
